// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage: owns the PC, drives the instruction-memory word address and
// registers the fetched word into IF/ID with valid/stall/redirect/halt control.
// Optional: FETCH_MISALIGN_TRAP_EN traps misaligned fetches; otherwise
// redirect targets are forced word-aligned.
// Revision: 1.0
// ============================================================================
module fetch_stage #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc_plus4,
  output logic              if_misalign,
  output logic              halted
);

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next4;
  logic [31:0] load_pc;
  logic        is_halt_word;
  logic        fetch_misaligned;

  assign imem_addr    = pc[ADDR_W+1:2];
  assign pc_next4     = pc + 32'd4;
  assign is_halt_word = (imem_data == ECALL) || (imem_data == EBREAK);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_flag;

  assign load_pc          = redirect_pc;
  assign fetch_misaligned = (pc[1:0] != 2'b00);
  assign if_misalign      = trap_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_flag <= 1'b0;
    end else if (redirect) begin
      trap_flag <= 1'b0;
    end else if (state == RUN && !stall && fetch_misaligned) begin
      trap_flag <= 1'b1;
    end
  end
`else
  assign load_pc          = redirect_pc & ~32'd3;
  assign fetch_misaligned = 1'b0;
  assign if_misalign      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_inst     <= NOP;
      if_pc       <= 32'd0;
      if_pc_plus4 <= 32'd4;
      halted      <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (redirect) pc <= load_pc;
          state <= RUN;
        end
        RUN: begin
          if (redirect) begin
            pc       <= load_pc;
            if_valid <= 1'b0;
          end else if (!stall) begin
            if_pc       <= pc;
            if_pc_plus4 <= pc_next4;
            if_valid    <= 1'b1;
            // A misaligned fetch presents a NOP and parks the PC on the bad address
            if (fetch_misaligned) begin
              if_inst <= NOP;
              state   <= HALT;
              halted  <= 1'b1;
            end else begin
              if_inst <= imem_data;
              pc      <= pc_next4;
              if (is_halt_word) begin
                state  <= HALT;
                halted <= 1'b1;
              end
            end
          end
        end
        HALT: begin
          if (redirect) begin
            pc       <= load_pc;
            if_valid <= 1'b0;
            halted   <= 1'b0;
            state    <= RUN;
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Testbench for fetch_stage: directed vector table then randomized run against a reference model.
module tb_fetch_stage;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              redirect = 1'b0;
  logic [31:0]       redirect_pc = 32'd0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [31:0]       if_pc;
  logic [31:0]       if_pc_plus4;
  logic              if_misalign;
  logic              halted;

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_misalign(if_misalign), .halted(halted)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = boot, 1 = running, 2 = halted
  int          m_mode = 0;
  logic [31:0] m_pc = 32'd0, m_inst = 32'h13, m_ipc = 32'd0, m_p4 = 32'd4;
  bit          m_valid = 0, m_mis = 0, m_halt = 0;

  function automatic logic [31:0] target(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  task automatic model_step();
    logic [31:0] word;
    if (rst) begin
      m_mode = 0; m_pc = 32'd0; m_valid = 0; m_inst = 32'h13;
      m_ipc = 32'd0; m_p4 = 32'd4; m_mis = 0; m_halt = 0;
    end else if (redirect) begin
      if (m_mode != 0) begin m_valid = 0; m_mis = 0; m_halt = 0; end
      m_pc = target(redirect_pc);
      m_mode = 1;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (!stall) begin
      if (m_mode == 2) begin
        m_valid = 0;
      end else begin
        m_valid = 1; m_ipc = m_pc; m_p4 = m_pc + 32'd4;
        if (m_pc % 4 != 0) begin
          m_inst = 32'h13; m_mis = 1; m_halt = 1; m_mode = 2;
        end else begin
          word = mem[(m_pc / 4) % 64];
          m_inst = word; m_pc = m_pc + 32'd4;
          if (word == 32'h73 || word == 32'h0010_0073) begin m_halt = 1; m_mode = 2; end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    bit          rst, stall, redir;
    logic [31:0] rpc;
    bit          valid;
    logic [31:0] ipc, inst;
    bit          halt, mis;
    int          addr;
  } vec_t;
  vec_t tv[$];

  task automatic add(input bit r, input bit s, input bit d, input logic [31:0] rpc,
                     input bit v, input logic [31:0] ipc, input logic [31:0] inst,
                     input bit h, input bit m, input int a);
    vec_t e;
    e.rst = r; e.stall = s; e.redir = d; e.rpc = rpc; e.valid = v;
    e.ipc = ipc; e.inst = inst; e.halt = h; e.mis = m; e.addr = a;
    tv.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h13 | (i << 7);
    mem[0] = 32'h00108093; mem[1] = 32'h00420213;
    mem[2] = 32'h00500283; mem[3] = 32'h001282b3;
    mem[5] = 32'h00000073;

    add(1,0,0,0,        0,32'h0,32'h13,0,0,0);
    add(1,0,0,0,        0,32'h0,32'h13,0,0,0);
    add(0,0,0,0,        0,32'h0,32'h13,0,0,0);          // boot cycle
    add(0,0,0,0,        1,32'h0,32'h00108093,0,0,1);
    add(0,0,0,0,        1,32'h4,32'h00420213,0,0,2);
    for (int i = 0; i < 3; i++) add(0,1,0,0, 1,32'h4,32'h00420213,0,0,2);
    add(0,0,0,0,        1,32'h8,32'h00500283,0,0,3);
    add(0,1,1,32'h20,   0,32'h8,32'h00500283,0,0,8);    // redirect beats stall
    add(0,0,0,0,        1,32'h20,32'h413,0,0,9);
    add(0,0,1,32'h10,   0,32'h20,32'h413,0,0,4);
    add(0,0,0,0,        1,32'h10,32'h213,0,0,5);
    add(0,0,0,0,        1,32'h14,32'h73,1,0,6);         // ECALL
    add(0,1,0,0,        1,32'h14,32'h73,1,0,6);
    for (int i = 0; i < 11; i++) add(0,0,0,0, 0,32'h14,32'h73,1,0,6);
    add(0,0,1,32'h0,    0,32'h14,32'h73,0,0,0);
    add(0,0,0,0,        1,32'h0,32'h00108093,0,0,1);
    add(0,0,1,32'hFC,   0,32'h0,32'h00108093,0,0,63);
    add(0,0,0,0,        1,32'hFC,32'h1F93,0,0,0);
    add(1,1,0,0,        0,32'h0,32'h13,0,0,0);          // reset mid-stall
    add(0,0,1,32'hFFFF_FFFC, 0,32'h0,32'h13,0,0,63);     // redirect during boot
    add(0,0,0,0,        1,32'hFFFF_FFFC,32'h1F93,0,0,0);
    add(0,0,1,32'h22,   0,32'hFFFF_FFFC,32'h1F93,0,0,8);
`ifdef FETCH_MISALIGN_TRAP_EN
    add(0,0,0,0,        1,32'h22,32'h13,1,1,8);
    add(0,0,0,0,        0,32'h22,32'h13,1,1,8);
    add(0,0,1,32'h0,    0,32'h22,32'h13,0,0,0);
`else
    add(0,0,0,0,        1,32'h20,32'h413,0,0,9);
    add(0,0,0,0,        1,32'h24,32'h493,0,0,10);
    add(0,0,1,32'h0,    0,32'h24,32'h493,0,0,0);
`endif

    for (int k = 0; k < tv.size(); k++) begin
      rst = tv[k].rst; stall = tv[k].stall; redirect = tv[k].redir; redirect_pc = tv[k].rpc;
      tick();
      chk($sformatf("v%0d if_valid", k), {31'd0, if_valid}, {31'd0, tv[k].valid});
      chk($sformatf("v%0d if_pc", k), if_pc, tv[k].ipc);
      chk($sformatf("v%0d if_inst", k), if_inst, tv[k].inst);
      chk($sformatf("v%0d if_pc_plus4", k), if_pc_plus4, tv[k].ipc + 32'd4);
      chk($sformatf("v%0d halted", k), {31'd0, halted}, {31'd0, tv[k].halt});
      chk($sformatf("v%0d if_misalign", k), {31'd0, if_misalign}, {31'd0, tv[k].mis});
      chk($sformatf("v%0d imem_addr", k), {26'd0, imem_addr}, tv[k].addr);
    end

    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 9))
        0:       mem[i] = 32'h0000_0073;
        1:       mem[i] = 32'h0010_0073;
        default: mem[i] = $urandom;
      endcase
    end

    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      stall    = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      tick();
      chk("rnd if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      chk("rnd if_inst", if_inst, m_inst);
      chk("rnd if_pc", if_pc, m_ipc);
      chk("rnd if_pc_plus4", if_pc_plus4, m_p4);
      chk("rnd halted", {31'd0, halted}, {31'd0, m_halt});
      chk("rnd if_misalign", {31'd0, if_misalign}, {31'd0, m_mis});
      chk("rnd imem_addr", {26'd0, imem_addr}, (m_pc / 4) % 64);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
